// File: rtl/mem_arbiter_if.sv
// Core-side request/response and memory-side signals of mem_arbiter, bundled as one interface.
// The master modport is the system side (core requesters plus memory); the slave modport is the arbiter.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic        mem_w_enb;
  logic        mem_r_enb;
  logic [31:0] mem_addr;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data;

  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_r_data,
    input  if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_w_enb, mem_r_enb, mem_addr, mem_w_data
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_r_data,
    output if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
    output mem_w_enb, mem_r_enb, mem_addr, mem_w_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one word-wide memory between fetch and load/store ports; 1-cycle response, sub-word stores as 2-cycle RMW.
// Losing/stalled requesters hold req until gnt. ARB_ROUND_ROBIN_EN selects round-robin over fixed D-first priority.
module mem_arbiter #(
  parameter int ADDR_BITS = 10
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic {IDLE, RMW} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  state_t      state;
  logic [31:0] rmw_addr;
  logic [31:0] rmw_data;

  logic        pick_d;
  logic        if_bad;
  logic        d_bad;
  logic [4:0]  lane_sh;
  logic [31:0] lane_mask;
  logic [31:0] merged;
  logic [31:0] ld_data;

`ifdef ARB_ROUND_ROBIN_EN
  logic        rr_is_d;
  assign pick_d = bus.d_req & (~bus.if_req | rr_is_d);
`else
  assign pick_d = bus.d_req;
`endif

  assign bus.d_gnt  = ~rst & (state == IDLE) & pick_d;
  assign bus.if_gnt = ~rst & (state == IDLE) & bus.if_req & ~pick_d;

  assign if_bad = ((bus.if_addr >> ADDR_BITS) != 32'd0) | (bus.if_addr[1:0] != 2'b00);
  assign d_bad  = ((bus.d_addr >> ADDR_BITS) != 32'd0)
                | (bus.d_size == SZ_BAD)
                | ((bus.d_size == SZ_HALF) & bus.d_addr[0])
                | ((bus.d_size == SZ_WORD) & (bus.d_addr[1:0] != 2'b00));

  // Lane shift is valid for half accesses too, since aligned halves have addr[0]=0.
  assign lane_sh = {bus.d_addr[1:0], 3'b000};

  always_comb begin
    lane_mask = 32'hFFFF_FFFF;
    if (bus.d_size == SZ_BYTE)
      lane_mask = 32'h0000_00FF;
    else if (bus.d_size == SZ_HALF)
      lane_mask = 32'h0000_FFFF;
  end

  assign merged  = (bus.mem_r_data & ~(lane_mask << lane_sh))
                 | ((bus.d_wdata & lane_mask) << lane_sh);
  assign ld_data = (bus.mem_r_data >> lane_sh) & lane_mask;

  always_comb begin
    bus.mem_w_enb  = 1'b0;
    bus.mem_r_enb  = 1'b0;
    bus.mem_addr   = 32'd0;
    bus.mem_w_data = 32'd0;
    if (!rst) begin
      if (state == RMW) begin
        bus.mem_w_enb  = 1'b1;
        bus.mem_addr   = rmw_addr;
        bus.mem_w_data = rmw_data;
      end else if (bus.d_gnt && !d_bad) begin
        bus.mem_addr = {bus.d_addr[31:2], 2'b00};
        if (bus.d_we && bus.d_size == SZ_WORD) begin
          bus.mem_w_enb  = 1'b1;
          bus.mem_w_data = bus.d_wdata;
        end else begin
          bus.mem_r_enb = 1'b1;
        end
      end else if (bus.if_gnt && !if_bad) begin
        bus.mem_r_enb = 1'b1;
        bus.mem_addr  = {bus.if_addr[31:2], 2'b00};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rmw_addr      <= 32'd0;
      rmw_data      <= 32'd0;
      bus.if_rvalid <= 1'b0;
      bus.if_err    <= 1'b0;
      bus.if_rdata  <= 32'd0;
      bus.d_rvalid  <= 1'b0;
      bus.d_err     <= 1'b0;
      bus.d_rdata   <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_is_d       <= 1'b1;
`endif
    end else begin
      bus.if_rvalid <= 1'b0;
      bus.if_err    <= 1'b0;
      bus.d_rvalid  <= 1'b0;
      bus.d_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.if_gnt) begin
            bus.if_rvalid <= 1'b1;
            bus.if_err    <= if_bad;
            bus.if_rdata  <= if_bad ? 32'd0 : bus.mem_r_data;
          end
          if (bus.d_gnt) begin
            if (d_bad) begin
              bus.d_rvalid <= 1'b1;
              bus.d_err    <= 1'b1;
              bus.d_rdata  <= 32'd0;
            end else if (bus.d_we && bus.d_size != SZ_WORD) begin
              state    <= RMW;
              rmw_addr <= {bus.d_addr[31:2], 2'b00};
              rmw_data <= merged;
            end else begin
              bus.d_rvalid <= 1'b1;
              bus.d_rdata  <= bus.d_we ? 32'd0 : ld_data;
            end
          end
        end
        RMW: begin
          bus.d_rvalid <= 1'b1;
          bus.d_rdata  <= 32'd0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef ARB_ROUND_ROBIN_EN
      if (bus.d_gnt && rr_is_d)
        rr_is_d <= 1'b0;
      else if (bus.if_gnt && !rr_is_d)
        rr_is_d <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed accesses push expected responses, a negedge monitor pops and compares.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.ADDR_BITS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model: combinational read, write at posedge; load port used only for preloading.
  logic [31:0] mem [0:255];
  logic        load_en  = 1'b0;
  logic [7:0]  load_idx = 8'd0;
  logic [31:0] load_val = 32'd0;

  assign bus.mem_r_data = mem[bus.mem_addr[9:2]];

  always @(posedge clk) begin
    if (load_en)
      mem[load_idx] <= load_val;
    else if (bus.mem_w_enb)
      mem[bus.mem_addr[9:2]] <= bus.mem_w_data;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] due;
  } exp_t;

  exp_t if_q[$];
  exp_t d_q[$];
  exp_t if_e;
  exp_t d_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: no grant within bound (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    if (bus.if_rvalid) begin
      if (if_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL if_unexpected_rvalid: got rdata %h err %b, expected no response", bus.if_rdata, bus.if_err);
      end else begin
        if_e = if_q.pop_front();
        check("if_rdata", bus.if_rdata, if_e.rdata);
        check("if_err", 32'(bus.if_err), 32'(if_e.err));
        check("if_latency", cyc, if_e.due);
      end
    end
    if (bus.d_rvalid) begin
      if (d_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL d_unexpected_rvalid: got rdata %h err %b, expected no response", bus.d_rdata, bus.d_err);
      end else begin
        d_e = d_q.pop_front();
        check("d_rdata", bus.d_rdata, d_e.rdata);
        check("d_err", 32'(bus.d_err), 32'(d_e.err));
        check("d_latency", cyc, d_e.due);
      end
    end
  end

  // Called #1 after a posedge; returns #1 after a posedge.
  task automatic if_access(input logic [31:0] addr, input logic [31:0] exp_rd, input logic exp_err);
    int n = 0;
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    @(negedge clk);
    while (!bus.if_gnt && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.if_gnt) begin
      timeout("if_grant");
    end else begin
      if_q.push_back('{rdata: exp_rd, err: exp_err, due: cyc + 1});
      check("if_mem_r_enb", 32'(bus.mem_r_enb), exp_err ? 32'd0 : 32'd1);
      check("if_mem_w_enb", 32'(bus.mem_w_enb), 32'd0);
    end
    @(posedge clk);
    #1 bus.if_req = 1'b0;
  endtask

  // chk: 0 = none, 1 = no memory enable at grant, 2 = sub-word RMW sequence
  task automatic d_access(input logic we, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd,
                          input logic exp_err, input int chk);
    int n = 0;
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_size  = size;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    @(negedge clk);
    while (!bus.d_gnt && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.d_gnt) begin
      timeout("d_grant");
    end else begin
      d_q.push_back('{rdata: exp_rd, err: exp_err,
                      due: cyc + ((we && size != 2'b10 && !exp_err) ? 2 : 1)});
      if (chk == 1) begin
        check("err_mem_w_enb", 32'(bus.mem_w_enb), 32'd0);
        check("err_mem_r_enb", 32'(bus.mem_r_enb), 32'd0);
      end
      if (chk == 2) begin
        check("rmw_grant_w_enb", 32'(bus.mem_w_enb), 32'd0);
        check("rmw_grant_r_enb", 32'(bus.mem_r_enb), 32'd1);
      end
    end
    @(posedge clk);
    #1 bus.d_req = 1'b0;
    if (chk == 2) begin
      @(negedge clk);
      check("rmw_w_enb", 32'(bus.mem_w_enb), 32'd1);
      check("rmw_addr", bus.mem_addr, {addr[31:2], 2'b00});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_size  = 2'b10;
    bus.d_addr  = 32'h20;
    bus.d_wdata = 32'd0;

    load_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      load_idx = 8'(i);
      load_val = (i == 4) ? 32'hDEADBEEF : (i == 12) ? 32'hCAFEF00D : 32'd0;
      @(posedge clk);
      #1;
    end
    load_en = 1'b0;

    @(negedge clk);
    check("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
    check("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
    check("rst_mem_w_enb", 32'(bus.mem_w_enb), 32'd0);
    check("rst_mem_r_enb", 32'(bus.mem_r_enb), 32'd0);
    check("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    check("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    check("rst_if_rdata", bus.if_rdata, 32'd0);
    check("rst_d_rdata", bus.d_rdata, 32'd0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;

    if_access(32'h10, 32'hDEADBEEF, 1'b0);
    if_access(32'h12, 32'd0, 1'b1);
    if_access(32'h400, 32'd0, 1'b1);

    d_access(1'b1, 2'b10, 32'h20, 32'h11223344, 32'd0, 1'b0, 0);
    d_access(1'b1, 2'b00, 32'h21, 32'h000000AA, 32'd0, 1'b0, 2);
    d_access(1'b0, 2'b10, 32'h20, 32'd0, 32'h1122AA44, 1'b0, 0);
    d_access(1'b0, 2'b01, 32'h22, 32'd0, 32'h00001122, 1'b0, 0);
    d_access(1'b0, 2'b00, 32'h23, 32'd0, 32'h00000011, 1'b0, 0);
    d_access(1'b0, 2'b01, 32'h20, 32'd0, 32'h0000AA44, 1'b0, 0);

    d_access(1'b1, 2'b01, 32'h21, 32'h0000BEEF, 32'd0, 1'b1, 1);
    d_access(1'b1, 2'b10, 32'h22, 32'h55555555, 32'd0, 1'b1, 1);
    d_access(1'b0, 2'b10, 32'h400, 32'd0, 32'd0, 1'b1, 1);
    d_access(1'b0, 2'b11, 32'h20, 32'd0, 32'd0, 1'b1, 1);
    d_access(1'b1, 2'b00, 32'h420, 32'h00000077, 32'd0, 1'b1, 1);
    d_access(1'b0, 2'b10, 32'h20, 32'd0, 32'h1122AA44, 1'b0, 0);
    drain();

    // Fresh reset so the round-robin pointer starts at D.
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_size  = 2'b10;
    bus.d_addr  = 32'h20;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
      check("arb_d_gnt", 32'(bus.d_gnt), (k % 2 == 0) ? 32'd1 : 32'd0);
      check("arb_if_gnt", 32'(bus.if_gnt), (k % 2 == 0) ? 32'd0 : 32'd1);
`else
      check("arb_d_gnt", 32'(bus.d_gnt), 32'd1);
      check("arb_if_gnt", 32'(bus.if_gnt), 32'd0);
`endif
      if (bus.d_gnt)
        d_q.push_back('{rdata: 32'h1122AA44, err: 1'b0, due: cyc + 1});
      if (bus.if_gnt)
        if_q.push_back('{rdata: 32'hDEADBEEF, err: 1'b0, due: cyc + 1});
      @(posedge clk);
    end
    #1;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    drain();

    // Reset lands in the RMW cycle of a byte store.
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_size  = 2'b00;
    bus.d_addr  = 32'h30;
    bus.d_wdata = 32'h00000055;
    n = 0;
    @(negedge clk);
    while (!bus.d_gnt && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.d_gnt)
      timeout("rmw_rst_grant");
    @(posedge clk);
    #1;
    rst       = 1'b1;
    bus.d_req = 1'b0;
    @(negedge clk);
    check("rmwrst_w_enb", 32'(bus.mem_w_enb), 32'd0);
    check("rmwrst_r_enb", 32'(bus.mem_r_enb), 32'd0);
    check("rmwrst_d_gnt", 32'(bus.d_gnt), 32'd0);
    check("rmwrst_if_gnt", 32'(bus.if_gnt), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rmwrst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    check("rmwrst_d_rdata", bus.d_rdata, 32'd0);
    check("rmwrst_if_rdata", bus.if_rdata, 32'd0);
    check("rmwrst_mem30", mem[12], 32'hCAFEF00D);
    @(posedge clk);
    #1;
    d_access(1'b0, 2'b10, 32'h30, 32'd0, 32'hCAFEF00D, 1'b0, 0);
    d_access(1'b1, 2'b00, 32'h30, 32'h00000055, 32'd0, 1'b0, 2);
    d_access(1'b0, 2'b10, 32'h30, 32'd0, 32'hCAFEF055, 1'b0, 0);
    drain();

    check("if_queue_empty", 32'(if_q.size()), 32'd0);
    check("d_queue_empty", 32'(d_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port unified `memory` between the core's instruction-fetch port (IF) and load/store port (D).
- Arbitrates requests and converts byte/halfword stores into read-modify-write (RMW) sequences, since `memory` writes only whole words.
- Returns registered read data and completion/error pulses to each requester.
- Sits between the core and `memory`; the `mem_*` ports connect directly to `memory`.

Parameters:
- ADDR_BITS, 10, byte-address width of the attached `memory`; must match its ADDR_BITS.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  combinational; request accepted this cycle.
- if_rvalid  out  1  one-cycle pulse; if_rdata/if_err valid.
- if_rdata  out  32  fetched word.
- if_err  out  1  with if_rvalid: misaligned or out-of-range address.
- d_req  in  1  data request; held with the other d_* inputs until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, LSB-aligned (byte in [7:0], half in [15:0]).
- d_gnt  out  1  combinational; request accepted this cycle.
- d_rvalid  out  1  one-cycle completion pulse for loads and stores.
- d_rdata  out  32  load data, lane-shifted to LSB and zero-extended; 0 for stores.
- d_err  out  1  with d_rvalid: misaligned, out-of-range or illegal size.
- mem_w_enb  out  1  to memory w_enb.
- mem_r_enb  out  1  to memory r_enb.
- mem_addr  out  32  word-aligned address to memory; bits [1:0] always 0.
- mem_w_data  out  32  to memory w_data.
- mem_r_data  in  32  from memory r_data (combinational read).

Behaviour:
- Reset: FSM=IDLE; if_rvalid, d_rvalid, if_err, d_err = 0; if_rdata, d_rdata = 0; RR pointer = D; no memory enables.
- While rst=1: mem_w_enb, mem_r_enb, if_gnt, d_gnt forced 0.
- FSM states: IDLE, RMW.
- IDLE arbitration:
  - Only one requester → it is granted.
  - Both requesting → winner chosen by priority rule (see Optional Feature); loser's gnt = 0, request stays pending.
- Error checks at grant. Error when any of:
  - address >= 2**ADDR_BITS;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - d_size=11;
  - if_addr[1:0]!=0.
  - On error: no memory enable asserted; rvalid+err pulse next cycle; rdata=0.
- Granted word read (IF, or D load of any size):
  - Same cycle: mem_r_enb=1, mem_addr={addr[31:2],2'b00}; mem_r_data registered at the edge.
  - rvalid next cycle, latency 1.
  - D load: byte = lane addr[1:0] → bits [7:0]; half = lane addr[1] → bits [15:0]; upper bits 0.
- Granted word store:
  - Same cycle: mem_w_enb=1, mem_w_data=d_wdata; memory updates at that edge.
  - d_rvalid next cycle; stay in IDLE.
- Granted byte/half store:
  - Grant cycle: mem_r_enb=1; old word latched; merged word built from addr lane and d_wdata; address latched.
  - Go to RMW.
- RMW state:
  - mem_w_enb=1 with the merged word at the latched address.
  - No grants this cycle; pending requests wait.
  - d_rvalid on the following cycle; return to IDLE.
- Back-to-back: a new grant is allowed in the same cycle as the previous response's rvalid. Sustained throughput is 1 access/cycle, except sub-word stores at 2 cycles each.
- Reset asserted during RMW: write suppressed, no rvalid, FSM returns to IDLE.
- A requester never receives two rvalids for one grant; responses come in grant order.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. On a conflict the RR pointer's port wins; the pointer flips to the other port after every grant to the pointer's port.
- Undefined: fixed priority, D always beats IF; RR pointer logic absent.

Test Plan:
- Reset, then IF read at 0x10 after memory preloaded with 0xDEADBEEF there → if_gnt same cycle, if_rvalid 1 cycle later, if_rdata=0xDEADBEEF, if_err=0.
- D word store 0x11223344 @0x20, then byte store 0xAA @0x21, then word load @0x20 → load returns 0x1122AA44; byte store asserts mem_w_enb only in the RMW cycle.
- D half load @0x22 of word 0x1122AA44 → d_rdata=0x00001122; byte load @0x23 → 0x00000011.
- Misaligned half @0x21, word @0x22, out-of-range @0x400 (ADDR_BITS=10) → d_rvalid with d_err=1, d_rdata=0, mem_w_enb and mem_r_enb never asserted.
- Both ports requesting continuously for 6 cycles:
  - without ARB_ROUND_ROBIN_EN → d_gnt all 6 cycles, if_gnt 0;
  - with the macro → grants alternate D, IF, D, IF, D, IF.
- rst pulsed during the RMW cycle of a byte store @0x30 → no write to 0x30 (word unchanged), no d_rvalid, all outputs 0, next request served normally.
